// File: rtl/sdram_arbit.sv
// -----------------------------------------------------------------------------
// sdram_arbit
// Command arbiter between the SDRAM init, auto-refresh, write and read blocks
// and the SDRAM pins. Holds INIT until power-up init completes, then grants one
// block at a time with fixed priority refresh > write > read, always passing
// through one ARBIT (NOP) cycle between grants.
//
// Ports
//   clk, rst                      clock, asynchronous active-high reset
//   flag_init_end                 init complete pulse
//   init_cmd/init_addr            init block command/address
//   ref_req, flag_ref_end         refresh request level / done pulse
//   ref_cmd/ref_addr, aref_en     refresh command/address, refresh grant
//   wr_req, flag_wr_end           write request level / segment done pulse
//   wr_cmd/wr_addr, wr_en         write command/address, write grant
//   rd_req, flag_rd_end           read request level / segment done pulse
//   rd_cmd/rd_addr, rd_en         read command/address, read grant
//   sdram_cke                     constant 1
//   sdram_cs_n..sdram_we_n        selected cmd[3:0], MSB first
//   sdram_ba, sdram_addr          constant bank, selected address
// -----------------------------------------------------------------------------
module sdram_arbit #(
  parameter logic [3:0]  CMD_NOP   = 4'b0111,
  parameter logic [12:0] IDLE_ADDR = 13'h0400,
  parameter logic [1:0]  SDRAM_BA  = 2'b00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flag_init_end,
  input  logic [3:0]  init_cmd,
  input  logic [12:0] init_addr,
  input  logic        ref_req,
  input  logic        flag_ref_end,
  input  logic [3:0]  ref_cmd,
  input  logic [12:0] ref_addr,
  output logic        aref_en,
  input  logic        wr_req,
  input  logic        flag_wr_end,
  input  logic [3:0]  wr_cmd,
  input  logic [12:0] wr_addr,
  output logic        wr_en,
  input  logic        rd_req,
  input  logic        flag_rd_end,
  input  logic [3:0]  rd_cmd,
  input  logic [12:0] rd_addr,
  output logic        rd_en,
  output logic        sdram_cke,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [1:0]  sdram_ba,
  output logic [12:0] sdram_addr
);

  localparam int unsigned ST_W   = 5;
  localparam int unsigned CMD_W  = 4;
  localparam int unsigned ADDR_W = 13;

  // One-hot state encoding
  localparam logic [ST_W-1:0] S_INIT  = 5'b00001;
  localparam logic [ST_W-1:0] S_ARBIT = 5'b00010;
  localparam logic [ST_W-1:0] S_AREF  = 5'b00100;
  localparam logic [ST_W-1:0] S_WRITE = 5'b01000;
  localparam logic [ST_W-1:0] S_READ  = 5'b10000;

  logic [ST_W-1:0]   state_q, state_d;
  logic              aref_en_q, wr_en_q, rd_en_q;
  logic [CMD_W-1:0]  sel_cmd_c;
  logic [ADDR_W-1:0] sel_addr_c;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: fixed priority only in ARBIT; busy states wait for own flag
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:  if (flag_init_end) state_d = S_ARBIT;
      S_ARBIT: begin
        if (ref_req)      state_d = S_AREF;
        else if (wr_req)  state_d = S_WRITE;
        else if (rd_req)  state_d = S_READ;
      end
      S_AREF:  if (flag_ref_end) state_d = S_ARBIT;
      S_WRITE: if (flag_wr_end)  state_d = S_ARBIT;
      S_READ:  if (flag_rd_end)  state_d = S_ARBIT;
      default: state_d = S_INIT;
    endcase
  end

  // Grants registered off the next state so each grant tracks its state exactly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aref_en_q <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
    end else begin
      aref_en_q <= (state_d == S_AREF);
      wr_en_q   <= (state_d == S_WRITE);
      rd_en_q   <= (state_d == S_READ);
    end
  end

  // Pin mux: combinational from registered state for a zero-cycle cmd path
  always_comb begin
    sel_cmd_c  = CMD_NOP;
    sel_addr_c = IDLE_ADDR;
    case (state_q)
      S_INIT: begin
        sel_cmd_c  = init_cmd;
        sel_addr_c = init_addr;
      end
      S_AREF: begin
        sel_cmd_c  = ref_cmd;
        sel_addr_c = ref_addr;
      end
      S_WRITE: begin
        sel_cmd_c  = wr_cmd;
        sel_addr_c = wr_addr;
      end
      S_READ: begin
        sel_cmd_c  = rd_cmd;
        sel_addr_c = rd_addr;
      end
      default: begin
        sel_cmd_c  = CMD_NOP;
        sel_addr_c = IDLE_ADDR;
      end
    endcase
  end

  assign aref_en     = aref_en_q;
  assign wr_en       = wr_en_q;
  assign rd_en       = rd_en_q;
  assign sdram_cke   = 1'b1;
  assign sdram_cs_n  = sel_cmd_c[3];
  assign sdram_ras_n = sel_cmd_c[2];
  assign sdram_cas_n = sel_cmd_c[1];
  assign sdram_we_n  = sel_cmd_c[0];
  assign sdram_ba    = SDRAM_BA;
  assign sdram_addr  = sel_addr_c;

endmodule

// File: tb/tb_sdram_arbit.sv
// -----------------------------------------------------------------------------
// tb_sdram_arbit
// Self-checking bench for sdram_arbit. Each test task drives inputs just after
// a falling edge and queues the expected grants/pins for the next falling edge;
// a monitor pops and compares them. Grant exclusivity is checked every cycle.
// -----------------------------------------------------------------------------
module tb_sdram_arbit;

  localparam logic [3:0]  NOP  = 4'b0111;
  localparam logic [12:0] IDLE = 13'h0400;

  localparam int E_INIT = 0;
  localparam int E_ARB  = 1;
  localparam int E_REF  = 2;
  localparam int E_WR   = 3;
  localparam int E_RD   = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        flag_init_end, ref_req, flag_ref_end, wr_req, flag_wr_end;
  logic        rd_req, flag_rd_end;
  logic [3:0]  init_cmd, ref_cmd, wr_cmd, rd_cmd;
  logic [12:0] init_addr, ref_addr, wr_addr, rd_addr;
  logic        aref_en, wr_en, rd_en, sdram_cke;
  logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_addr;

  typedef struct packed {
    logic [2:0]  en;    // {aref, wr, rd}
    logic [3:0]  cmd;
    logic [12:0] addr;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_vec  = 0;
  int    n_miss = 0;

  always #5 clk = ~clk;

  sdram_arbit dut (
    .clk(clk), .rst(rst),
    .flag_init_end(flag_init_end), .init_cmd(init_cmd), .init_addr(init_addr),
    .ref_req(ref_req), .flag_ref_end(flag_ref_end), .ref_cmd(ref_cmd),
    .ref_addr(ref_addr), .aref_en(aref_en),
    .wr_req(wr_req), .flag_wr_end(flag_wr_end), .wr_cmd(wr_cmd),
    .wr_addr(wr_addr), .wr_en(wr_en),
    .rd_req(rd_req), .flag_rd_end(flag_rd_end), .rd_cmd(rd_cmd),
    .rd_addr(rd_addr), .rd_en(rd_en),
    .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
    .sdram_ba(sdram_ba), .sdram_addr(sdram_addr)
  );

  // Queue the expected outcome of the current cycle, then advance one cycle
  task automatic step(input string nm, input int st);
    exp_t e;
    case (st)
      E_INIT:  e = '{en: 3'b000, cmd: init_cmd, addr: init_addr};
      E_REF:   e = '{en: 3'b100, cmd: ref_cmd,  addr: ref_addr};
      E_WR:    e = '{en: 3'b010, cmd: wr_cmd,   addr: wr_addr};
      E_RD:    e = '{en: 3'b001, cmd: rd_cmd,   addr: rd_addr};
      default: e = '{en: 3'b000, cmd: NOP,      addr: IDLE};
    endcase
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
    #1;
  endtask

  // Scoreboard monitor plus per-cycle grant exclusivity
  always @(negedge clk) begin : mon
    exp_t  e;
    string nm;
    n_vec++;
    if ($countones({aref_en, wr_en, rd_en}) > 1) begin
      n_miss++;
      $display("FAIL grant_onehot t=%0t got en=%b%b%b want at most one high",
               $time, aref_en, wr_en, rd_en);
    end
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_vec++;
      if ({aref_en, wr_en, rd_en} !== e.en) begin
        n_miss++;
        $display("FAIL %s grants t=%0t got %b want %b", nm, $time,
                 {aref_en, wr_en, rd_en}, e.en);
      end
      n_vec++;
      if ({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_addr} !==
          {e.cmd, e.addr}) begin
        n_miss++;
        $display("FAIL %s pins t=%0t got cmd=%b addr=%h want cmd=%b addr=%h",
                 nm, $time, {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n},
                 sdram_addr, e.cmd, e.addr);
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    flag_init_end = 1'b0; flag_ref_end = 1'b0; flag_wr_end = 1'b0; flag_rd_end = 1'b0;
    ref_req = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    init_cmd = 4'b0001; init_addr = 13'h0111;
    ref_cmd  = 4'b0010; ref_addr  = 13'h0222;
    wr_cmd   = 4'b0100; wr_addr   = 13'h0333;
    rd_cmd   = 4'b0011; rd_addr   = 13'h0444;
    repeat (3) @(negedge clk);
    #1;
    n_vec++;
    if ({aref_en, wr_en, rd_en, sdram_cke, sdram_ba} !== 6'b000100) begin
      n_miss++;
      $display("FAIL reset_outputs got en=%b cke=%b ba=%b want en=000 cke=1 ba=00",
               {aref_en, wr_en, rd_en}, sdram_cke, sdram_ba);
    end
    n_vec++;
    if ({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_addr} !==
        {4'b0001, 13'h0111}) begin
      n_miss++;
      $display("FAIL reset_pins got cmd=%b addr=%h want init mux 0001/0111",
               {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, sdram_addr);
    end
    rst = 1'b0;
  endtask

  // Power-up: reqs ignored in INIT, init_end in cycle 20 leads to ARBIT
  task automatic test_powerup();
    ref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    for (int i = 1; i < 20; i++) begin
      init_cmd = 4'(i);
      step("powerup_init", E_INIT);
    end
    ref_req = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    flag_init_end = 1'b1;
    step("powerup_init_end", E_ARB);
    flag_init_end = 1'b0;
    repeat (2) step("powerup_idle", E_ARB);
  endtask

  task automatic test_single_read();
    rd_req = 1'b1; rd_cmd = 4'b0011;
    step("rd_grant", E_RD);
    rd_req = 1'b0; rd_cmd = 4'b0101;
    step("rd_cmd_follow", E_RD);
    flag_rd_end = 1'b1;
    step("rd_end", E_ARB);
    flag_rd_end = 1'b0;
    step("rd_idle", E_ARB);
  endtask

  task automatic test_priority();
    ref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
    step("prio_ref_first", E_REF);
    ref_req = 1'b0;
    step("prio_ref_hold", E_REF);
    flag_ref_end = 1'b1;
    step("prio_gap1", E_ARB);
    flag_ref_end = 1'b0;
    step("prio_wr_second", E_WR);
    wr_req = 1'b0;
    step("prio_wr_hold", E_WR);
    flag_wr_end = 1'b1;
    step("prio_gap2", E_ARB);
    flag_wr_end = 1'b0;
    step("prio_rd_third", E_RD);
    rd_req = 1'b0;
  endtask

  // In READ: other flags and reqs have no effect
  task automatic test_foreign_flag();
    flag_wr_end = 1'b1; flag_ref_end = 1'b1; flag_init_end = 1'b1;
    step("foreign_flags", E_RD);
    flag_wr_end = 1'b0; flag_ref_end = 1'b0; flag_init_end = 1'b0;
    ref_req = 1'b1; wr_req = 1'b1;
    step("foreign_reqs", E_RD);
    ref_req = 1'b0; wr_req = 1'b0;
    step("foreign_stay", E_RD);
  endtask

  task automatic test_back_to_back();
    rd_req = 1'b1; flag_rd_end = 1'b1;
    step("b2b_gap", E_ARB);
    flag_rd_end = 1'b0;
    step("b2b_regrant", E_RD);
    rd_req = 1'b0; flag_rd_end = 1'b1;
    step("b2b_end", E_ARB);
    flag_rd_end = 1'b0;
    step("b2b_idle", E_ARB);
  endtask

  task automatic test_reset_mid_write();
    wr_req = 1'b1;
    step("rstw_grant", E_WR);
    wr_req = 1'b0;
    step("rstw_hold", E_WR);
    rst = 1'b1;
    #1;
    n_vec++;
    if ({aref_en, wr_en, rd_en} !== 3'b000) begin
      n_miss++;
      $display("FAIL rstw_async_grant got en=%b want 000", {aref_en, wr_en, rd_en});
    end
    n_vec++;
    if ({sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_addr} !==
        {init_cmd, init_addr}) begin
      n_miss++;
      $display("FAIL rstw_async_pins got cmd=%b addr=%h want %b/%h",
               {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, sdram_addr,
               init_cmd, init_addr);
    end
    step("rstw_in_reset", E_INIT);
    rst = 1'b0; wr_req = 1'b1;
    repeat (3) step("rstw_held_init", E_INIT);
    wr_req = 1'b0; flag_init_end = 1'b1;
    step("rstw_reinit", E_ARB);
    flag_init_end = 1'b0;
    ref_req = 1'b1;
    step("rstw_ref_after", E_REF);
    ref_req = 1'b0; flag_ref_end = 1'b1;
    step("rstw_ref_end", E_ARB);
    flag_ref_end = 1'b0;
    step("rstw_final_idle", E_ARB);
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_single_read();
    test_priority();
    test_foreign_flag();
    test_back_to_back();
    test_reset_mid_write();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
